// File: rtl/input_strobe_gen_pkg.sv
// Shared definitions for the CPU input-port front end.
// Holds the debounce FSM state type and the default port width.
package cpu_io_pkg;

   localparam int IO_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE        = 2'd0,
      DEB_PRESS   = 2'd1,
      PRESSED     = 2'd2,
      DEB_RELEASE = 2'd3
   } dbn_state_t;

endpackage

// File: rtl/input_strobe_gen_if.sv
// Board-side inputs, CPU-side acknowledge and the capture outputs of input_strobe_gen.
// The strobe generator is the slave; whoever drives the switches and ack is the master.
interface input_strobe_gen_if
   import cpu_io_pkg::*;
#(
   parameter int WIDTH = IO_WIDTH
);

   logic [WIDTH-1:0] raw_data;
   logic             raw_btn;
   logic             ack;
   logic [WIDTH-1:0] data_out;
   logic             strobe;
   logic             data_valid;
   logic             overrun;

   modport master (
      output raw_data,
      output raw_btn,
      output ack,
      input  data_out,
      input  strobe,
      input  data_valid,
      input  overrun
   );

   modport slave (
      input  raw_data,
      input  raw_btn,
      input  ack,
      output data_out,
      output strobe,
      output data_valid,
      output overrun
   );

endinterface

// File: rtl/input_strobe_gen_sync2.sv
// Two-flop synchroniser for signals arriving asynchronously to clk.
// Each bit is synchronised independently; multi-bit users must tolerate per-bit skew.
module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_q, meta_d;
   logic [WIDTH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/input_strobe_gen.sv
// Synchronises the switch bus and load button, debounces the button and emits one
// capture strobe per accepted press, with sticky valid/overrun tracking for the CPU side.
module input_strobe_gen
   import cpu_io_pkg::*;
#(
   parameter int WIDTH           = IO_WIDTH,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                clk,
   input  logic                clr,
   input_strobe_gen_if.slave   io
);

   localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0] data_s;
   logic             btn_s;

   sync2 #(.WIDTH(WIDTH)) u_sync_data (
      .clk (clk),
      .clr (clr),
      .d   (io.raw_data),
      .q   (data_s)
   );

   sync2 #(.WIDTH(1)) u_sync_btn (
      .clk (clk),
      .clr (clr),
      .d   (io.raw_btn),
      .q   (btn_s)
   );

   dbn_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             capture;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             strobe_q, strobe_d;
   logic             data_valid_q, data_valid_d;
   logic             overrun_q, overrun_d;

   // Debounce FSM: the counter restarts on every state change and saturates at CNT_MAX
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (btn_s) begin
               state_d = DEB_PRESS;
               cnt_d   = '0;
            end
         end
         DEB_PRESS: begin
            if (!btn_s) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = PRESSED;
               cnt_d   = '0;
               capture = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (!btn_s) begin
               state_d = DEB_RELEASE;
               cnt_d   = '0;
            end
         end
         DEB_RELEASE: begin
            if (btn_s) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_MAX) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // A simultaneous ack consumes the old word, so the new capture is not an overrun
   always_comb begin
      strobe_d     = capture;
      data_out_d   = capture ? data_s : data_out_q;
      data_valid_d = data_valid_q;
      overrun_d    = overrun_q;
      if (capture && io.ack) begin
         data_valid_d = 1'b1;
         overrun_d    = 1'b0;
      end else if (capture) begin
         overrun_d    = overrun_q | data_valid_q;
         data_valid_d = 1'b1;
      end else if (io.ack) begin
         data_valid_d = 1'b0;
         overrun_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         strobe_q     <= 1'b0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         strobe_q     <= strobe_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   assign io.data_out   = data_out_q;
   assign io.strobe     = strobe_q;
   assign io.data_valid = data_valid_q;
   assign io.overrun    = overrun_q;

endmodule

// File: tb/tb_input_strobe_gen.sv
// Directed bench for input_strobe_gen: a DEBOUNCE_CYCLES=4 instance and a
// DEBOUNCE_CYCLES=1 instance sharing clock and reset.
module tb_input_strobe_gen;
   import cpu_io_pkg::*;

   logic clk = 1'b0;
   logic clr = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   input_strobe_gen_if #(.WIDTH(32)) io0 ();
   input_strobe_gen_if #(.WIDTH(32)) io1 ();

   input_strobe_gen #(.WIDTH(32), .DEBOUNCE_CYCLES(4)) u_dut0 (
      .clk (clk),
      .clr (clr),
      .io  (io0.slave)
   );

   input_strobe_gen #(.WIDTH(32), .DEBOUNCE_CYCLES(1)) u_dut1 (
      .clk (clk),
      .clr (clr),
      .io  (io1.slave)
   );

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic ack_pulse();
      io0.ack = 1'b1;
      tick();
      io0.ack = 1'b0;
   endtask

   task automatic test_reset();
      ticks(2);
      checks++;
      if (io0.data_out !== 32'h0 || io0.strobe !== 1'b0 || io0.data_valid !== 1'b0 || io0.overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs0: got data_out=%h strobe=%b valid=%b overrun=%b, want all 0",
                  io0.data_out, io0.strobe, io0.data_valid, io0.overrun);
      end
      checks++;
      if (io1.data_out !== 32'h0 || io1.strobe !== 1'b0 || io1.data_valid !== 1'b0 || io1.overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs1: got data_out=%h strobe=%b valid=%b overrun=%b, want all 0",
                  io1.data_out, io1.strobe, io1.data_valid, io1.overrun);
      end
      clr = 1'b0;
      ticks(5);
      checks++;
      if (u_dut0.state_q !== IDLE) begin
         errors++;
         $display("FAIL reset_state: got %0d want IDLE", u_dut0.state_q);
      end
   endtask

   task automatic test_clean_press();
      int extra;
      io0.raw_data = 32'hDEADBEEF;
      io0.raw_btn  = 1'b1;
      for (int e = 0; e <= 5; e++) begin
         tick();
         checks++;
         if (io0.strobe !== 1'b0) begin
            errors++;
            $display("FAIL clean_early_strobe: edge %0d got strobe=%b want 0", e, io0.strobe);
         end
      end
      tick();
      checks++;
      if (io0.strobe !== 1'b1 || io0.data_out !== 32'hDEADBEEF || io0.data_valid !== 1'b1 || io0.overrun !== 1'b0) begin
         errors++;
         $display("FAIL clean_strobe_edge6: got strobe=%b data_out=%h valid=%b overrun=%b, want 1 deadbeef 1 0",
                  io0.strobe, io0.data_out, io0.data_valid, io0.overrun);
      end
      extra = 0;
      io0.raw_data = 32'h12345678;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (io0.strobe === 1'b1) extra++;
      end
      checks++;
      if (extra != 0 || io0.data_out !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL clean_hold: got %0d extra strobes data_out=%h, want 0 and deadbeef", extra, io0.data_out);
      end
      io0.raw_btn = 1'b0;
      ticks(12);
      checks++;
      if (u_dut0.state_q !== IDLE || io0.data_valid !== 1'b1) begin
         errors++;
         $display("FAIL clean_release: got state=%0d valid=%b, want IDLE and 1", u_dut0.state_q, io0.data_valid);
      end
      ack_pulse();
      checks++;
      if (io0.data_valid !== 1'b0 || io0.overrun !== 1'b0) begin
         errors++;
         $display("FAIL clean_ack: got valid=%b overrun=%b want 0 0", io0.data_valid, io0.overrun);
      end
   endtask

   task automatic test_bounce();
      int seen;
      logic pattern [0:4];
      pattern = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
      io0.raw_data = 32'hBADBAD00;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         io0.raw_btn = pattern[i];
         tick();
         if (io0.strobe === 1'b1) seen++;
      end
      io0.raw_btn = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (io0.strobe === 1'b1) seen++;
      end
      checks++;
      if (seen != 0 || io0.data_out !== 32'hDEADBEEF || io0.data_valid !== 1'b0) begin
         errors++;
         $display("FAIL bounce_reject: got %0d strobes data_out=%h valid=%b, want 0 deadbeef 0",
                  seen, io0.data_out, io0.data_valid);
      end
      checks++;
      if (u_dut0.state_q !== IDLE) begin
         errors++;
         $display("FAIL bounce_state: got %0d want IDLE", u_dut0.state_q);
      end
   endtask

   task automatic press_and_wait(input logic [31:0] word, input string name);
      bit seen;
      seen = 1'b0;
      io0.raw_data = word;
      io0.raw_btn  = 1'b1;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (io0.strobe === 1'b1) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_timeout: got no strobe within 20 cycles, want one", name);
      end
   endtask

   task automatic release_btn();
      io0.raw_btn = 1'b0;
      ticks(12);
   endtask

   task automatic test_overrun();
      press_and_wait(32'h1, "ovr_first");
      checks++;
      if (io0.data_out !== 32'h1 || io0.data_valid !== 1'b1 || io0.overrun !== 1'b0) begin
         errors++;
         $display("FAIL ovr_first: got data_out=%h valid=%b overrun=%b, want 1 1 0",
                  io0.data_out, io0.data_valid, io0.overrun);
      end
      release_btn();
      press_and_wait(32'h2, "ovr_second");
      checks++;
      if (io0.data_out !== 32'h2 || io0.data_valid !== 1'b1 || io0.overrun !== 1'b1) begin
         errors++;
         $display("FAIL ovr_second: got data_out=%h valid=%b overrun=%b, want 2 1 1",
                  io0.data_out, io0.data_valid, io0.overrun);
      end
      release_btn();
      checks++;
      if (io0.overrun !== 1'b1) begin
         errors++;
         $display("FAIL ovr_sticky: got overrun=%b want 1", io0.overrun);
      end
      ack_pulse();
      checks++;
      if (io0.data_valid !== 1'b0 || io0.overrun !== 1'b0 || io0.data_out !== 32'h2) begin
         errors++;
         $display("FAIL ovr_ack: got valid=%b overrun=%b data_out=%h, want 0 0 2",
                  io0.data_valid, io0.overrun, io0.data_out);
      end
   endtask

   task automatic test_back_to_back_ack();
      press_and_wait(32'h3, "b2b_first");
      release_btn();
      io0.raw_data = 32'h4;
      io0.raw_btn  = 1'b1;
      ticks(6);
      io0.ack = 1'b1;
      tick();
      io0.ack = 1'b0;
      checks++;
      if (io0.strobe !== 1'b1 || io0.data_valid !== 1'b1 || io0.overrun !== 1'b0 || io0.data_out !== 32'h4) begin
         errors++;
         $display("FAIL ack_with_strobe: got strobe=%b valid=%b overrun=%b data_out=%h, want 1 1 0 4",
                  io0.strobe, io0.data_valid, io0.overrun, io0.data_out);
      end
      release_btn();
   endtask

   task automatic test_reset_mid_debounce();
      int seen;
      io0.raw_data = 32'h55AA55AA;
      io0.raw_btn  = 1'b1;
      ticks(3);
      #1 clr = 1'b1;
      #1;
      checks++;
      if (io0.data_out !== 32'h0 || io0.strobe !== 1'b0 || io0.data_valid !== 1'b0 || io0.overrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: got data_out=%h strobe=%b valid=%b overrun=%b, want all 0",
                  io0.data_out, io0.strobe, io0.data_valid, io0.overrun);
      end
      checks++;
      if (u_dut0.state_q !== IDLE) begin
         errors++;
         $display("FAIL reset_async_state: got %0d want IDLE", u_dut0.state_q);
      end
      tick();
      io0.raw_btn = 1'b0;
      tick();
      clr = 1'b0;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (io0.strobe === 1'b1) seen++;
      end
      checks++;
      if (seen != 0 || u_dut0.state_q !== IDLE || io0.data_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_after: got %0d strobes state=%0d valid=%b, want 0 IDLE 0",
                  seen, u_dut0.state_q, io0.data_valid);
      end
   endtask

   task automatic test_debounce_one();
      int seen;
      io1.raw_data = 32'hCAFE0001;
      io1.raw_btn  = 1'b1;
      for (int e = 0; e <= 2; e++) begin
         tick();
         checks++;
         if (io1.strobe !== 1'b0) begin
            errors++;
            $display("FAIL deb1_early: edge %0d got strobe=%b want 0", e, io1.strobe);
         end
      end
      tick();
      checks++;
      if (io1.strobe !== 1'b1 || io1.data_out !== 32'hCAFE0001 || io1.data_valid !== 1'b1) begin
         errors++;
         $display("FAIL deb1_strobe_edge3: got strobe=%b data_out=%h valid=%b, want 1 cafe0001 1",
                  io1.strobe, io1.data_out, io1.data_valid);
      end
      tick();
      checks++;
      if (io1.strobe !== 1'b0) begin
         errors++;
         $display("FAIL deb1_single: got strobe=%b at edge 4, want 0", io1.strobe);
      end
      io1.raw_btn = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (io1.strobe === 1'b1) seen++;
      end
      checks++;
      if (seen != 0 || u_dut1.state_q !== IDLE) begin
         errors++;
         $display("FAIL deb1_release: got %0d strobes state=%0d, want 0 IDLE", seen, u_dut1.state_q);
      end
   endtask

   initial begin
      io0.raw_data = '0;
      io0.raw_btn  = 1'b0;
      io0.ack      = 1'b0;
      io1.raw_data = '0;
      io1.raw_btn  = 1'b0;
      io1.ack      = 1'b0;
      @(negedge clk);
      test_reset();
      test_clean_press();
      test_bounce();
      test_overrun();
      test_back_to_back_ack();
      test_reset_mid_debounce();
      test_debounce_one();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/input_strobe_gen.md
Name: input_strobe_gen

Overview:
- Front-end for the CPU input port. Takes raw, asynchronous switch data and a raw "load" pushbutton from the board.
- Synchronises both, debounces the button, and produces a clean single-cycle strobe with a stable data word.
- Outputs feed the input-port register's enable and data pins directly.
- Tracks whether a captured word has been consumed, and flags overruns.

Parameters:
- WIDTH, 32, data width of switch bus and data_out.
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised cycles required to accept a press or release; legal range 1..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden).

Ports:
- clk  input  1  system clock.
- clr  input  1  asynchronous active-high reset.
- raw_data  input  WIDTH  switch bus, asynchronous to clk.
- raw_btn  input  1  load pushbutton, asynchronous, active-high, bouncy.
- ack  input  1  one-cycle pulse from the CPU side: captured word consumed.
- data_out  output  WIDTH  captured, synchronised switch word; wire to the input port data input.
- strobe  output  1  one-cycle capture pulse; wire to the input port enable.
- data_valid  output  1  sticky: word captured and not yet acknowledged.
- overrun  output  1  sticky: a new word was captured while data_valid=1 and no ack arrived.

Behaviour:
- Reset:
  - clr asserted at any time, including mid-debounce, asynchronously forces all outputs to 0.
  - Sync flops reset to 0, counter to 0, FSM to IDLE.
- Synchronisation:
  - raw_data and raw_btn each pass through 2 flops, producing data_s and btn_s.
  - No combinational path from raw_* to any output.
- FSM states: IDLE, DEB_PRESS, PRESSED, DEB_RELEASE. All registered.
  - IDLE: btn_s=1 -> DEB_PRESS, cnt<=0. Otherwise stay.
  - DEB_PRESS, btn_s=0 -> IDLE, cnt<=0 (bounce rejected, no strobe).
  - DEB_PRESS, btn_s=1, cnt<DEBOUNCE_CYCLES-1 -> cnt<=cnt+1.
  - DEB_PRESS, btn_s=1, cnt==DEBOUNCE_CYCLES-1 -> PRESSED, cnt<=0, strobe<=1, data_out<=data_s.
  - PRESSED: btn_s=0 -> DEB_RELEASE, cnt<=0. Holding the button never re-strobes.
  - DEB_RELEASE, btn_s=1 -> PRESSED, cnt<=0.
  - DEB_RELEASE, btn_s=0, cnt==DEBOUNCE_CYCLES-1 -> IDLE. Otherwise cnt<=cnt+1. Release never strobes.
- strobe: registered, high exactly one cycle per accepted press, 0 in every other cycle.
- Latency: if raw_btn is high and stable from before edge k, strobe is high between edges k+2+DEBOUNCE_CYCLES and k+3+DEBOUNCE_CYCLES.
- data_out:
  - Changes only on the strobe edge; holds otherwise.
  - Captured word equals raw_data as it stood 2 edges earlier.
- data_valid / overrun, priority per edge:
  - strobe-edge and ack together -> data_valid stays 1, overrun<=0 (old word consumed, new word pending).
  - strobe-edge only -> overrun<=overrun|data_valid, then data_valid<=1.
  - ack only -> data_valid<=0, overrun<=0.
  - ack while data_valid=0 -> no effect beyond clearing overrun (already 0).
- Counter:
  - Never exceeds DEBOUNCE_CYCLES-1 and never wraps.
  - DEBOUNCE_CYCLES=1 gives a transition on the first stable cycle in DEB_* states.

Decomposition:
- Shared package (cpu_io_pkg):
  - FSM state enum dbn_state_t {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE}.
  - Default width constant IO_WIDTH=32.
- One sub-module, sync2: parameterised-width two-flop synchroniser with async active-high clr.
  - Instantiated once for raw_data (WIDTH) and once for raw_btn (1).
- FSM, counter and flag logic stay in the top module.

Test Plan (DEBOUNCE_CYCLES=4 unless stated):
- Reset mid-debounce: press raw_btn, assert clr 3 cycles later -> all outputs 0 immediately (before the next clk edge), FSM IDLE, no strobe after release of clr while btn low.
- Clean press: raw_data=32'hDEADBEEF, raw_btn 0->1 before edge 0 and held -> strobe=1 only between edges 6 and 7, data_out=32'hDEADBEEF, data_valid=1; holding 50 cycles gives no further strobe.
- Bounce rejection: raw_btn high 2 cycles, low 1, high 2, then low -> no strobe, data_out unchanged, FSM returns to IDLE.
- Overrun: two clean presses (data 32'h1 then 32'h2) with no ack -> after 2nd strobe data_out=32'h2, data_valid=1, overrun=1; single ack pulse -> both 0.
- Simultaneous ack and strobe: ack pulsed on the strobe edge of 2nd press while data_valid=1 -> data_valid=1, overrun=0, data_out=2nd word.
- DEBOUNCE_CYCLES=1 build: stable press before edge 0 -> strobe high between edges 3 and 4; release returns FSM to IDLE with no strobe.
